code_sequence_counter: RTL and testbench
========================================

# code_sequence_counter

Parametrised, clocked code generator that steps a binary state counter and presents it as binary, Gray, or one-hot. It supports enable, up/down, synchronous load and clear, and signals wrap-around. It replaces the combinational Gray/one-hot encoder in sequencing paths that need a registered, steppable code source, such as mux select rotation or Gray-coded pointers. All outputs are registered and mutually consistent in every cycle.

## Interface
- WIDTH, 3: counter width in bits; legal range 2..6.
- MODE, 1: output encoding; 0 = binary, 1 = Gray, 2 = one-hot; any other value behaves as 0.
- CODE_W, 2**WIDTH: width of the code output (derived; not overridden).

- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of the count to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load (binary).
- en  input  1  step enable.
- up  input  1  direction; 1 = increment, 0 = decrement.
- count  output  WIDTH  registered binary state.
- code  output  CODE_W  registered encoded state per MODE.
- wrap  output  1  one-cycle pulse: the last step crossed the boundary.
- code_err  output  1  sticky flag: Gray code changed by other than exactly 1 bit on a step.

## Operation
- Next-state priority per cycle: clr > load > en > hold.
  - clr: count becomes 0.
  - load: count becomes load_val.
  - en with up = 1: count becomes count+1 mod 2^WIDTH.
  - en with up = 0: count becomes count-1 mod 2^WIDTH.
- Encoding of code, computed from the next count and registered together with count:
  - MODE 0: code[WIDTH-1:0] = count; upper bits are 0.
  - MODE 1: code[WIDTH-1:0] = count ^ (count >> 1); upper bits are 0.
  - MODE 2: code = 1 << count, so exactly one bit is set; count 0 sets bit 0.
- wrap:
  - Registered.
  - Asserts for one cycle after an en step with up = 1 from 2^WIDTH-1 to 0, or with up = 0 from 0 to 2^WIDTH-1.
  - Never asserts on clr, load, or hold, even if the value jumps across the boundary.
- code_err:
  - Checked only when MODE = 1 and an en step occurs (no clr or load that cycle).
  - Sets if the popcount of (old code XOR new code) is not 1.
  - Stays set until reset or clr.
  - Tied to 0 for other modes.
  - Never expected to set in correct RTL; it exists as an in-silicon self-check.
- Simultaneous clr and load: clr wins, load_val is ignored, and code_err clears.
- load with en: load wins; no step and no wrap.

## Timing
- Reset (rst_n low, asynchronous): count = 0, wrap = 0, code_err = 0.
- code at reset: 0 for MODE 0/1; 1 (bit 0) for MODE 2.
- Reset release: synchronous to clk by the integrator; the first step can occur on the first rising edge after rst_n goes high.
- Latency: one cycle from a clr/load/en sample to the updated count, code, and wrap.
- count and code always update on the same edge; there is no cycle where they disagree.
- Reset asserted mid-step: outputs go to reset values immediately; the pending step is lost.
- Throughput: one step per cycle when en is held high.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Action: WIDTH=3, MODE=1; drive rst_n low asynchronously mid-cycle.
  - Check: count = 0, code = 0, wrap = 0, code_err = 0 immediately; they hold while clr/load/en toggle.
- Gray up-count:
  - Action: WIDTH=3, MODE=1; en = 1, up = 1 for 9 cycles.
  - Check: code sequence 000, 001, 011, 010, 110, 111, 101, 100, 000, 001.
  - Check: wrap = 1 only in the cycle count reads 0 after 7.
  - Check: code_err stays 0.
- One-hot down-count:
  - Action: WIDTH=3, MODE=2; load load_val = 2, then en = 1, up = 0 for 4 cycles.
  - Check: code 0x04, 0x02, 0x01, 0x80, 0x40.
  - Check: wrap pulses once, on the 0 -> 7 step.
- Priority:
  - Action 1: WIDTH=3, MODE=0, count = 5; assert clr = 1, load = 1 (load_val = 6), en = 1 together.
  - Check 1: count = 0 next cycle, wrap = 0.
  - Action 2: load = 1 with en = 1, load_val = 7.
  - Check 2: count = 7, wrap = 0.
- Hold and width corner:
  - Action: WIDTH=6, MODE=2; en = 0 for 10 cycles, then load load_val = 63.
  - Check: code = 1 << 63; code stays constant while en = 0.
  - Action: one up step from 63.
  - Check: count = 0, code = 1, wrap = 1.
- code_err:
  - Action: WIDTH=4, MODE=1; run full up and down sweeps of 32 steps each, including wraps.
  - Check: code_err = 0 throughout.
  - Action: force a bad internal step in simulation.
  - Check: code_err sets and stays set until clr.

Source files
------------

// File: rtl/code_sequence_counter.sv
// ---------------------------------------------------------------------------
// code_sequence_counter
//
// Registered, steppable code source. A binary state counter is stepped up or
// down and presented as binary, Gray or one-hot. count and code are both
// computed from the same next-state value and registered on the same edge,
// so they always agree.
//
// Parameters
//   WIDTH    counter width, 2..6
//   MODE     0 = binary, 1 = Gray, 2 = one-hot (other values act as binary)
//   CODE_W   derived code width, 2**WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear (highest priority)
//   load       synchronous load of load_val
//   load_val   value to load (binary)
//   en         step enable
//   up         step direction, 1 = increment
//   count      registered binary state
//   code       registered encoded state
//   wrap       one-cycle pulse after an en step crossed the boundary
//   code_err   sticky Gray self-check flag (MODE 1 only)
// ---------------------------------------------------------------------------
module code_sequence_counter #(
    parameter  int WIDTH  = 3,
    parameter  int MODE   = 1,
    localparam int CODE_W = 2 ** WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              up,
    output logic [WIDTH-1:0]  count,
    output logic [CODE_W-1:0] code,
    output logic              wrap,
    output logic              code_err
);

    localparam logic [CODE_W-1:0] CODE_RST = (MODE == 2) ? CODE_W'(1) : '0;

    logic [WIDTH-1:0]  count_q, count_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              wrap_q, wrap_d;
    logic              code_err_q, code_err_d;
    logic              step;
    logic [WIDTH-1:0]  gray_diff;
    logic              gray_one_bit;

    function automatic logic [CODE_W-1:0] encode(input logic [WIDTH-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        case (MODE)
            1:       r[WIDTH-1:0] = v ^ (v >> 1);
            2:       r = CODE_W'(1) << v;
            default: r[WIDTH-1:0] = v;
        endcase
        return r;
    endfunction

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        step    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            step = 1'b1;
            if (up) begin
                count_d = count_q + 1'b1;
                wrap_d  = (count_q == '1);
            end else begin
                count_d = count_q - 1'b1;
                wrap_d  = (count_q == '0);
            end
        end
        code_d = encode(count_d);
    end

    // Compare the code actually held in the register against the new code,
    // so a corrupted code register is caught, not just a bad encoder.
    always_comb begin
        gray_diff    = code_q[WIDTH-1:0] ^ code_d[WIDTH-1:0];
        gray_one_bit = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);
        code_err_d   = code_err_q;
        if (MODE != 1) begin
            code_err_d = 1'b0;
        end else if (clr) begin
            code_err_d = 1'b0;
        end else if (step && !gray_one_bit) begin
            code_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            code_q     <= CODE_RST;
            wrap_q     <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            code_q     <= code_d;
            wrap_q     <= wrap_d;
            code_err_q <= code_err_d;
        end
    end

    assign count    = count_q;
    assign code     = code_q;
    assign wrap     = wrap_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_code_sequence_counter.sv
// ---------------------------------------------------------------------------
// tb_code_sequence_counter
//
// Five instances with different WIDTH/MODE share one stimulus stream; an
// integer reference model tracks each one and every output is compared
// after every clock. Directed sequences are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_code_sequence_counter;

    localparam int N = 5;
    localparam int PW [N] = '{3, 3, 3, 6, 4};
    localparam int PM [N] = '{1, 2, 0, 2, 1};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr   = 1'b0;
    logic       load  = 1'b0;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic [5:0] load_val = '0;

    logic [63:0] o_cnt  [N];
    logic [63:0] o_code [N];
    logic        o_wrap [N];
    logic        o_err  [N];

    int m_cnt  [N];
    bit m_wrap [N];
    bit m_err  [N];
    bit inject = 1'b0;

    logic [15:0] fv;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = PW[g];
        localparam int M = PM[g];
        logic [W-1:0]      c;
        logic [2**W-1:0]   k;
        logic              w;
        logic              e;
        code_sequence_counter #(.WIDTH(W), .MODE(M)) u (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[W-1:0]),
            .en       (en),
            .up       (up),
            .count    (c),
            .code     (k),
            .wrap     (w),
            .code_err (e)
        );
        assign o_cnt[g]  = 64'(c);
        assign o_code[g] = 64'(k);
        assign o_wrap[g] = w;
        assign o_err[g]  = e;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_code(input int i);
        int c;
        c = m_cnt[i];
        case (PM[i])
            1:       return 64'(c ^ (c / 2));
            2:       return 64'(1) << c;
            default: return 64'(c);
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        int n, c;
        bit w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            n = 1 << PW[i];
            c = m_cnt[i];
            w = 1'b0;
            if (clr) begin
                c = 0;
                m_err[i] = 1'b0;
            end else if (load) begin
                c = int'(load_val) % n;
            end else if (en) begin
                if (up) begin
                    w = (c == n - 1);
                    c = (c + 1) % n;
                end else begin
                    w = (c == 0);
                    c = (c + n - 1) % n;
                end
                if (inject && i == 4) m_err[i] = 1'b1;
            end
            m_cnt[i]  = c;
            m_wrap[i] = w;
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d.count", i), o_cnt[i], 64'(m_cnt[i]));
            check($sformatf("u%0d.code", i), o_code[i], exp_code(i));
            check($sformatf("u%0d.wrap", i), 64'(o_wrap[i]), 64'(m_wrap[i]));
            check($sformatf("u%0d.code_err", i), 64'(o_err[i]), 64'(m_err[i]));
        end
    endtask

    // Called at a falling edge: drive, clock, update model, check next falling edge.
    task automatic cycle(input bit c, input bit l, input bit e, input bit u, input logic [5:0] lv);
        clr = c; load = l; en = e; up = u; load_val = lv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_cycle();
        cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 63)));
    endtask

    task automatic async_reset_test();
        en = 1'b1; up = 1'b1;
        @(posedge clk);
        model_step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        repeat (4) rand_cycle();
        rst_n = 1'b1;
    endtask

    int gseq  [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 1};
    int ohseq [5]  = '{4, 2, 1, 128, 64};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        repeat (3) rand_cycle();
        rst_n = 1'b1;

        // Gray up-count from 0 with wrap
        cycle(1, 0, 0, 0, 0);
        check("gray_seq", o_code[0], 64'(gseq[0]));
        for (int k = 1; k < 10; k++) begin
            cycle(0, 0, 1, 1, 0);
            check("gray_seq", o_code[0], 64'(gseq[k]));
            check("gray_wrap", 64'(o_wrap[0]), (k == 8) ? 64'd1 : 64'd0);
            check("gray_err", 64'(o_err[0]), 64'd0);
        end

        // One-hot down-count through 0
        cycle(0, 1, 0, 0, 6'd2);
        check("onehot_seq", o_code[1], 64'(ohseq[0]));
        for (int k = 1; k < 5; k++) begin
            cycle(0, 0, 1, 0, 0);
            check("onehot_seq", o_code[1], 64'(ohseq[k]));
            check("onehot_wrap", 64'(o_wrap[1]), (k == 3) ? 64'd1 : 64'd0);
        end

        // Priority: clr > load > en
        cycle(0, 1, 0, 0, 6'd5);
        check("prio_pre", o_cnt[2], 64'd5);
        cycle(1, 1, 1, 1, 6'd6);
        check("prio_clr_cnt", o_cnt[2], 64'd0);
        check("prio_clr_wrap", 64'(o_wrap[2]), 64'd0);
        cycle(0, 1, 1, 1, 6'd7);
        check("prio_load_cnt", o_cnt[2], 64'd7);
        check("prio_load_wrap", 64'(o_wrap[2]), 64'd0);

        // Hold and widest one-hot corner
        repeat (10) cycle(0, 0, 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        cycle(0, 1, 0, 0, 6'd63);
        check("w6_code63", o_code[3], 64'h8000_0000_0000_0000);
        repeat (10) begin
            cycle(0, 0, 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            check("w6_hold", o_code[3], 64'h8000_0000_0000_0000);
        end
        cycle(0, 0, 1, 1, 0);
        check("w6_wrap_cnt", o_cnt[3], 64'd0);
        check("w6_wrap_code", o_code[3], 64'd1);
        check("w6_wrap", 64'(o_wrap[3]), 64'd1);

        // Gray self-check: clean sweeps, then a corrupted code register
        cycle(1, 0, 0, 0, 0);
        repeat (32) cycle(0, 0, 1, 1, 0);
        repeat (32) cycle(0, 0, 1, 0, 0);
        check("err_clean", 64'(o_err[4]), 64'd0);
        fv = 16'((((m_cnt[4] + 1) % 16)) ^ (((m_cnt[4] + 1) % 16) / 2));
        force g_dut[4].u.code_q = fv;
        inject = 1'b1;
        cycle(0, 0, 1, 1, 0);
        release g_dut[4].u.code_q;
        inject = 1'b0;
        check("err_set", 64'(o_err[4]), 64'd1);
        repeat (5) cycle(0, 0, 1, 1'($urandom_range(0, 1)), 0);
        cycle(0, 1, 0, 0, 6'd3);
        check("err_sticky", 64'(o_err[4]), 64'd1);
        cycle(1, 0, 0, 0, 0);
        check("err_clr", 64'(o_err[4]), 64'd0);

        repeat (300) rand_cycle();
        async_reset_test();
        repeat (100) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
